// File: rtl/pc_unit.sv
// Fetch-stage program counter: picks the next fetch address from redirect, buffered redirect,
// return-address stack, predicted jump or sequential increment; sticky halt.
module pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int unsigned      INC        = 4,
  parameter int unsigned      RAS_DEPTH  = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             stall,
  input  logic             halt,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_addr,
  input  logic             jump_valid,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] iaddr,
  output logic             halted,
  output logic             pend_valid,
  output logic             ras_empty
);

  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [WIDTH-1:0] pend_addr;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] ras_cnt;

  logic             adv, take_redir, take_pend, squash, do_push, do_pop;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] iaddr_nxt, pend_addr_nxt, wr_data;
  logic             pend_valid_nxt, wr_en;
  logic [PTR_W-1:0] top_ptr_nxt, wr_idx;
  logic [CNT_W-1:0] ras_cnt_nxt;

  // Advance qualification; the squash blocks RAS updates on a wrong-path redirect cycle.
  always_comb begin
    adv        = ihit & ~stall & ~halted & ~halt;
    take_redir = adv & redir_valid;
    take_pend  = adv & ~redir_valid & pend_valid;
    squash     = take_redir | take_pend;
    do_pop     = adv & ~squash & ras_pop & ~ras_empty;
    do_push    = adv & ~squash & ras_push;
    ras_top    = ras_mem[top_ptr];
  end

  // Next fetch address, first match wins.
  always_comb begin
    iaddr_nxt = iaddr;
    if (adv) begin
      if (redir_valid)     iaddr_nxt = redir_addr;
      else if (pend_valid) iaddr_nxt = pend_addr;
      else if (do_pop)     iaddr_nxt = ras_top;
      else if (jump_valid) iaddr_nxt = jump_addr;
      else                 iaddr_nxt = iaddr + WIDTH'(INC);
    end
  end

  // Buffered redirect: youngest unapplied redirect is kept until fetch can advance.
  always_comb begin
    pend_valid_nxt = pend_valid;
    pend_addr_nxt  = pend_addr;
    if (!halted) begin
      if (squash) pend_valid_nxt = 1'b0;
      if (redir_valid && !adv) begin
        pend_valid_nxt = 1'b1;
        pend_addr_nxt  = redir_addr;
      end
    end
  end

  // Circular RAS; push+pop together replaces the top entry in place.
  always_comb begin
    top_ptr_nxt = top_ptr;
    ras_cnt_nxt = ras_cnt;
    wr_en       = 1'b0;
    wr_idx      = top_ptr;
    wr_data     = push_addr;
    if (do_push && do_pop) begin
      wr_en = 1'b1;
    end else if (do_push) begin
      top_ptr_nxt = top_ptr + PTR_W'(1);
      wr_en       = 1'b1;
      wr_idx      = top_ptr + PTR_W'(1);
      if (ras_cnt != CNT_W'(RAS_DEPTH)) ras_cnt_nxt = ras_cnt + CNT_W'(1);
    end else if (do_pop) begin
      top_ptr_nxt = top_ptr - PTR_W'(1);
      ras_cnt_nxt = ras_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      iaddr      <= RESET_ADDR;
      halted     <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      top_ptr    <= '0;
      ras_cnt    <= '0;
      ras_empty  <= 1'b1;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_mem[i] <= '0;
    end else begin
      iaddr      <= iaddr_nxt;
      halted     <= halted | halt;
      pend_valid <= pend_valid_nxt;
      pend_addr  <= pend_addr_nxt;
      top_ptr    <= top_ptr_nxt;
      ras_cnt    <= ras_cnt_nxt;
      ras_empty  <= (ras_cnt_nxt == '0);
      if (wr_en) ras_mem[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        nRST, ihit, stall, halt;
  logic        redir_valid, jump_valid, ras_push, ras_pop;
  logic [31:0] redir_addr, jump_addr, push_addr;
  logic [31:0] iaddr;
  logic        halted, pend_valid, ras_empty;

  int n_checks = 0;
  int n_pass   = 0;

  pc_unit dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
    .redir_valid(redir_valid), .redir_addr(redir_addr),
    .jump_valid(jump_valid), .jump_addr(jump_addr),
    .ras_push(ras_push), .push_addr(push_addr), .ras_pop(ras_pop),
    .iaddr(iaddr), .halted(halted), .pend_valid(pend_valid), .ras_empty(ras_empty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic clr();
    ihit = 1'b0; stall = 1'b0; halt = 1'b0;
    redir_valid = 1'b0; jump_valid = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    redir_addr = '0; jump_addr = '0; push_addr = '0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0;
    clr();
    step(); step();
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pend", 32'(pend_valid), 32'd0);
    check("rst_empty", 32'(ras_empty), 32'd1);

    // Sequential fetch, then reset mid-run
    nRST = 1'b1; ihit = 1'b1;
    step(); check("seq_4", iaddr, 32'h4);
    step(); check("seq_8", iaddr, 32'h8);
    step(); check("seq_c", iaddr, 32'hC);
    nRST = 1'b0;
    step(); check("midrst", iaddr, 32'h0);
    nRST = 1'b1; ihit = 1'b0;

    // Redirect buffered while fetch stalled
    redir_valid = 1'b1; redir_addr = 32'h100;
    step(); check("pend_hold", iaddr, 32'h0); check("pend_set", 32'(pend_valid), 32'd1);
    redir_valid = 1'b0; ihit = 1'b1;
    step(); check("pend_apply", iaddr, 32'h100); check("pend_clr", 32'(pend_valid), 32'd0);
    ihit = 1'b0; redir_valid = 1'b1; redir_addr = 32'h110;
    step();
    redir_addr = 32'h120;
    step(); check("pend_hold2", iaddr, 32'h100); check("pend_set2", 32'(pend_valid), 32'd1);
    redir_valid = 1'b0; ihit = 1'b1;
    step(); check("pend_youngest", iaddr, 32'h120);
    stall = 1'b1;
    step(); check("stall_hold", iaddr, 32'h120);
    stall = 1'b0;

    // Redirect beats jump and pop; RAS untouched
    ras_push = 1'b1; push_addr = 32'hAA;
    step(); check("push_aa", iaddr, 32'h124); check("nonempty", 32'(ras_empty), 32'd0);
    ras_push = 1'b0; redir_valid = 1'b1; redir_addr = 32'h200;
    jump_valid = 1'b1; jump_addr = 32'h300; ras_pop = 1'b1;
    step(); check("redir_prio", iaddr, 32'h200);
    redir_valid = 1'b0; jump_valid = 1'b0;
    step(); check("pop_aa", iaddr, 32'hAA); check("empty_aa", 32'(ras_empty), 32'd1);
    ras_pop = 1'b0;

    // Overflow: five pushes into a depth-4 RAS, oldest lost
    ras_push = 1'b1;
    push_addr = 32'h10; step(); check("push10", iaddr, 32'hAE);
    push_addr = 32'h20; step(); check("push20", iaddr, 32'hB2);
    push_addr = 32'h30; step(); check("push30", iaddr, 32'hB6);
    push_addr = 32'h40; step(); check("push40", iaddr, 32'hBA);
    push_addr = 32'h50; step(); check("push50", iaddr, 32'hBE);
    ras_push = 1'b0; ras_pop = 1'b1;
    step(); check("pop50", iaddr, 32'h50);
    step(); check("pop40", iaddr, 32'h40);
    step(); check("pop30", iaddr, 32'h30);
    step(); check("pop20", iaddr, 32'h20); check("empty_ovf", 32'(ras_empty), 32'd1);
    step(); check("pop_empty_seq", iaddr, 32'h24);
    jump_valid = 1'b1; jump_addr = 32'h400;
    step(); check("pop_empty_jump", iaddr, 32'h400);
    jump_valid = 1'b0; ras_pop = 1'b0;

    // Address wrap, then push+pop in one cycle
    redir_valid = 1'b1; redir_addr = 32'hFFFF_FFFC;
    step(); check("to_top", iaddr, 32'hFFFF_FFFC);
    redir_valid = 1'b0;
    step(); check("wrap", iaddr, 32'h0);
    ras_push = 1'b1; push_addr = 32'h80;
    step(); check("push80", iaddr, 32'h4);
    push_addr = 32'h90; ras_pop = 1'b1;
    step(); check("pushpop", iaddr, 32'h80);
    ras_push = 1'b0;
    step(); check("pop90", iaddr, 32'h90); check("empty_pp", 32'(ras_empty), 32'd1);
    ras_push = 1'b1; push_addr = 32'hA0;
    step(); check("pushpop_empty", iaddr, 32'h94); check("pp_empty_fill", 32'(ras_empty), 32'd0);
    ras_push = 1'b0;
    step(); check("popa0", iaddr, 32'hA0);
    ras_pop = 1'b0;

    // Jump ignored without advance; halt freezes everything
    ihit = 1'b0; jump_valid = 1'b1; jump_addr = 32'h500;
    step(); check("jump_noadv", iaddr, 32'hA0);
    jump_valid = 1'b0; ihit = 1'b1; halt = 1'b1;
    step(); check("halt_iaddr", iaddr, 32'hA0); check("halt_set", 32'(halted), 32'd1);
    halt = 1'b0; redir_valid = 1'b1; redir_addr = 32'h600;
    jump_valid = 1'b1; jump_addr = 32'h700; ras_push = 1'b1; push_addr = 32'hB0;
    step(); step();
    check("halt_frz", iaddr, 32'hA0);
    check("halt_nopend", 32'(pend_valid), 32'd0);
    check("halt_noras", 32'(ras_empty), 32'd1);
    check("halt_sticky", 32'(halted), 32'd1);
    clr(); nRST = 1'b0;
    step(); check("unhalt_iaddr", iaddr, 32'h0); check("unhalt", 32'(halted), 32'd0);
    nRST = 1'b1; ihit = 1'b1;
    step(); check("after_halt", iaddr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
